// File: rtl/rom_toggle_responder_if.sv
// ROM fetch toggle handshake plus SDRAM read command port, bundled for one
// responder instance. "master" is the layer/controller side, "slave" is the
// responder itself.
interface rom_toggle_responder_if #(
    parameter int unsigned ADDR_W = 25
);
    // Layer side (toggle handshake)
    logic [23:0]       rom_addr;
    logic              rom_req;
    logic [15:0]       rom_data;
    logic              rom_ack;
    logic              cache_inv;

    // SDRAM controller side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_rdy;
    logic [15:0]       mem_dout;
    logic              mem_dv;

    modport master (
        output rom_addr, rom_req, cache_inv, mem_rdy, mem_dout, mem_dv,
        input  rom_data, rom_ack, mem_addr, mem_rd
    );

    modport slave (
        input  rom_addr, rom_req, cache_inv, mem_rdy, mem_dout, mem_dv,
        output rom_data, rom_ack, mem_addr, mem_rd
    );
endinterface

// File: rtl/rom_toggle_responder.sv
// SDRAM-side responder for a toggle-handshake ROM fetch port. A pending
// request (rom_req != rom_ack) becomes one SDRAM read; the returned word is
// handed back and the toggle completed. A one-entry last-word cache short-cuts
// repeated fetches, and a fetch whose address moved while in flight is
// discarded and reissued at the new address.
module rom_toggle_responder #(
    parameter int unsigned       ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] BASE_WADDR = 25'h0020000,
    parameter bit                CACHE_EN   = 1'b1
) (
    input  logic                            clk,
    input  logic                            RESET,
    rom_toggle_responder_if.slave           bus,
    output logic                            busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t      state;
    logic [23:0] addr_q;
    logic        req_q;
    logic [23:0] last_addr;
    logic [15:0] last_data;
    logic        valid;

    logic        pending;
    logic        hit;
    logic [ADDR_W-1:0] next_mem_addr;

    // Request detection, cache lookup and SDRAM address (wraps modulo 2^ADDR_W)
    always_comb begin
        pending       = bus.rom_req ^ bus.rom_ack;
        hit           = CACHE_EN && valid && (bus.rom_addr == last_addr) && !bus.cache_inv;
        next_mem_addr = BASE_WADDR + ADDR_W'(bus.rom_addr);
    end

    // Handshake FSM: all outputs and the cache are registered here
    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= IDLE;
            busy         <= 1'b0;
            bus.rom_ack  <= 1'b0;
            bus.rom_data <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            addr_q       <= '0;
            req_q        <= 1'b0;
            last_addr    <= '0;
            last_data    <= '0;
            valid        <= 1'b0;
        end else begin
            // Invalidate in any state; a WAIT completion below may not re-set
            // valid in the same cycle because its update is gated on cache_inv.
            if (bus.cache_inv) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        addr_q <= bus.rom_addr;
                        req_q  <= bus.rom_req;
                        if (hit) begin
                            bus.rom_data <= last_data;
                            bus.rom_ack  <= bus.rom_req;
                        end else begin
                            bus.mem_addr <= next_mem_addr;
                            bus.mem_rd   <= 1'b1;
                            busy         <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (bus.mem_rd && bus.mem_rdy) begin
                        bus.mem_rd <= 1'b0;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.mem_dv) begin
                        if (bus.rom_addr == addr_q) begin
                            bus.rom_data <= bus.mem_dout;
                            bus.rom_ack  <= req_q;
                            if (!bus.cache_inv) begin
                                last_addr <= addr_q;
                                last_data <= bus.mem_dout;
                                valid     <= 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // Address moved while in flight: drop the word and
                            // refetch at the current address without acking.
                            addr_q       <= bus.rom_addr;
                            req_q        <= bus.rom_req;
                            bus.mem_addr <= next_mem_addr;
                            bus.mem_rd   <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    bus.mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_toggle_responder.sv
// Directed bench for rom_toggle_responder: one cached instance and one
// uncached instance with a high base address to exercise address wrap.
module tb_rom_toggle_responder;

    logic clk;
    logic RESET;
    logic busy;
    logic busy2;

    int unsigned checks;
    int unsigned failures;

    rom_toggle_responder_if #(.ADDR_W(25)) bus ();
    rom_toggle_responder_if #(.ADDR_W(25)) bus2 ();

    rom_toggle_responder #(
        .ADDR_W    (25),
        .BASE_WADDR(25'h0020000),
        .CACHE_EN  (1'b1)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus.slave),
        .busy (busy)
    );

    rom_toggle_responder #(
        .ADDR_W    (25),
        .BASE_WADDR(25'h1F00000),
        .CACHE_EN  (1'b0)
    ) dut_nc (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus2.slave),
        .busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept the command in ISSUE, then return one word on the next cycle
    task automatic mem_complete(input logic [15:0] d);
        bus.mem_rdy = 1'b1;
        step();
        bus.mem_rdy = 1'b0;
        bus.mem_dv   = 1'b1;
        bus.mem_dout = d;
        step();
        bus.mem_dv   = 1'b0;
    endtask

    task automatic mem_complete2(input logic [15:0] d);
        bus2.mem_rdy = 1'b1;
        step();
        bus2.mem_rdy = 1'b0;
        bus2.mem_dv   = 1'b1;
        bus2.mem_dout = d;
        step();
        bus2.mem_dv   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        bus2.rom_addr  = '0;
        bus2.rom_req   = 1'b0;
        bus2.cache_inv = 1'b0;
        bus2.mem_rdy   = 1'b0;
        bus2.mem_dout  = '0;
        bus2.mem_dv    = 1'b0;

        // Reset with random activity on every input
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rom_addr  = 24'($urandom);
            bus.rom_req   = 1'($urandom);
            bus.cache_inv = 1'($urandom);
            bus.mem_rdy   = 1'($urandom);
            bus.mem_dout  = 16'($urandom);
            bus.mem_dv    = 1'($urandom);
            step();
        end
        check("rst_ack",   32'(bus.rom_ack),  32'h0);
        check("rst_data",  32'(bus.rom_data), 32'h0);
        check("rst_mem_rd",32'(bus.mem_rd),   32'h0);
        check("rst_maddr", 32'(bus.mem_addr), 32'h0);
        check("rst_busy",  32'(busy),         32'h0);

        RESET         = 1'b0;
        bus.rom_addr  = 24'h001234;
        bus.rom_req   = 1'b0;
        bus.cache_inv = 1'b0;
        bus.mem_rdy   = 1'b0;
        bus.mem_dout  = '0;
        bus.mem_dv    = 1'b0;
        step();
        check("idle_mem_rd", 32'(bus.mem_rd), 32'h0);

        // Miss: first request after reset
        bus.rom_req = 1'b1;
        step();
        check("miss_mem_rd", 32'(bus.mem_rd),   32'h1);
        check("miss_maddr",  32'(bus.mem_addr), 32'h0021234);
        check("miss_busy",   32'(busy),         32'h1);
        step();
        check("miss_hold_rd",   32'(bus.mem_rd),   32'h1);
        check("miss_hold_addr", 32'(bus.mem_addr), 32'h0021234);
        bus.mem_rdy = 1'b1;
        step();
        bus.mem_rdy = 1'b0;
        check("miss_rd_drop", 32'(bus.mem_rd), 32'h0);
        step();
        step();
        check("miss_no_ack_yet", 32'(bus.rom_ack), 32'h0);
        bus.mem_dv   = 1'b1;
        bus.mem_dout = 16'hBEEF;
        step();
        bus.mem_dv   = 1'b0;
        check("miss_data", 32'(bus.rom_data), 32'hBEEF);
        check("miss_ack",  32'(bus.rom_ack),  32'h1);
        check("miss_busy0",32'(busy),         32'h0);

        // Hit: same address, toggle back
        bus.rom_req = 1'b0;
        step();
        check("hit_ack",   32'(bus.rom_ack),  32'h0);
        check("hit_data",  32'(bus.rom_data), 32'hBEEF);
        check("hit_mem_rd",32'(bus.mem_rd),   32'h0);
        step();
        check("hit_mem_rd2",32'(bus.mem_rd),  32'h0);
        check("hit_busy",   32'(busy),        32'h0);

        // Stale: address moves during WAIT
        bus.rom_addr = 24'h000010;
        bus.rom_req  = 1'b1;
        step();
        check("stale_maddr1", 32'(bus.mem_addr), 32'h0020010);
        bus.mem_rdy = 1'b1;
        step();
        bus.mem_rdy  = 1'b0;
        bus.rom_addr = 24'h000020;
        step();
        bus.mem_dv   = 1'b1;
        bus.mem_dout = 16'h1111;
        step();
        bus.mem_dv   = 1'b0;
        check("stale_no_ack", 32'(bus.rom_ack),  32'h0);
        check("stale_reissue",32'(bus.mem_rd),   32'h1);
        check("stale_maddr2", 32'(bus.mem_addr), 32'h0020020);
        check("stale_data",   32'(bus.rom_data), 32'hBEEF);
        mem_complete(16'h2222);
        check("stale_data2", 32'(bus.rom_data), 32'h2222);
        check("stale_ack",   32'(bus.rom_ack),  32'h1);

        // Invalidate pulse, then re-request the cached address
        bus.cache_inv = 1'b1;
        step();
        bus.cache_inv = 1'b0;
        bus.rom_req   = 1'b0;
        step();
        check("inv_miss_rd", 32'(bus.mem_rd),  32'h1);
        check("inv_no_ack",  32'(bus.rom_ack), 32'h1);

        // cache_inv coincident with the data return
        bus.mem_rdy = 1'b1;
        step();
        bus.mem_rdy   = 1'b0;
        bus.mem_dv    = 1'b1;
        bus.mem_dout  = 16'h3333;
        bus.cache_inv = 1'b1;
        step();
        bus.mem_dv    = 1'b0;
        bus.cache_inv = 1'b0;
        check("invdv_data", 32'(bus.rom_data), 32'h3333);
        check("invdv_ack",  32'(bus.rom_ack),  32'h0);
        bus.rom_req = 1'b1;
        step();
        check("invdv_next_miss", 32'(bus.mem_rd), 32'h1);
        mem_complete(16'h4444);
        check("refill_ack", 32'(bus.rom_ack), 32'h1);
        bus.rom_req = 1'b0;
        step();
        check("refill_hit_data", 32'(bus.rom_data), 32'h4444);
        check("refill_hit_ack",  32'(bus.rom_ack),  32'h0);
        check("refill_hit_rd",   32'(bus.mem_rd),   32'h0);

        // Stray mem_dv in IDLE is ignored
        bus.mem_dv   = 1'b1;
        bus.mem_dout = 16'h5555;
        step();
        bus.mem_dv   = 1'b0;
        check("stray_data", 32'(bus.rom_data), 32'h4444);
        check("stray_ack",  32'(bus.rom_ack),  32'h0);

        // Reset in WAIT, then a late data return
        bus.rom_addr = 24'h000030;
        bus.rom_req  = 1'b1;
        step();
        bus.mem_rdy = 1'b1;
        step();
        bus.mem_rdy = 1'b0;
        check("rmid_busy", 32'(busy), 32'h1);
        RESET       = 1'b1;
        bus.rom_req = 1'b0;
        step();
        RESET = 1'b0;
        check("rmid_busy0", 32'(busy), 32'h0);
        step();
        step();
        bus.mem_dv   = 1'b1;
        bus.mem_dout = 16'hDEAD;
        step();
        bus.mem_dv   = 1'b0;
        check("rmid_ack",  32'(bus.rom_ack),  32'h0);
        check("rmid_data", 32'(bus.rom_data), 32'h0);
        check("rmid_busy2",32'(busy),         32'h0);
        bus.rom_addr = 24'h000020;
        bus.rom_req  = 1'b1;
        step();
        check("rmid_cache_invalid", 32'(bus.mem_rd), 32'h1);
        mem_complete(16'h6666);
        check("rmid_refetch", 32'(bus.rom_data), 32'h6666);

        // Uncached instance: wrap of base + address, repeats always miss
        bus2.rom_addr = 24'hFFFFFF;
        bus2.rom_req  = 1'b1;
        step();
        check("nc_wrap_addr", 32'(bus2.mem_addr), 32'h0EFFFFF);
        check("nc_rd1",       32'(bus2.mem_rd),   32'h1);
        mem_complete2(16'hABCD);
        check("nc_data1", 32'(bus2.rom_data), 32'hABCD);
        check("nc_ack1",  32'(bus2.rom_ack),  32'h1);
        bus2.rom_req = 1'b0;
        step();
        check("nc_rd2",  32'(bus2.mem_rd),  32'h1);
        check("nc_ack2_pending", 32'(bus2.rom_ack), 32'h1);
        mem_complete2(16'hABCE);
        check("nc_data2", 32'(bus2.rom_data), 32'hABCE);
        check("nc_ack2",  32'(bus2.rom_ack),  32'h0);
        check("nc_busy",  32'(busy2),         32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
